// File: rtl/mems_spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between the scan sequencer and host path; MEMS_ARB_TIMEOUT_EN adds a transfer watchdog.
// Latency: grant and addr register one edge after an IDLE decision; start is high for the ISSUE cycle; done registers one edge after busy falls.
// Backpressure: requests are levels held until done; no new grant while pause is high or while a done pulse is being shown.
module mems_spi_arbiter #(
    parameter int ADDR_W         = 18,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              pause,
    input  logic              mems_SPI_busy,
    output logic              mems_SPI_start,
    output logic [ADDR_W-1:0] addr,
    output logic              scan_grant,
    output logic              host_grant,
    output logic              scan_done,
    output logic              host_done,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              scan_grant_q, scan_grant_d;
    logic              host_grant_q, host_grant_d;
    logic              scan_done_q, scan_done_d;
    logic              host_done_q, host_done_d;
    logic              last_host_q, last_host_d;
    logic              pick_host;
    logic              finish;
    logic              expire;

`ifdef MEMS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Counter sits at zero outside a transfer, so it is clear on entering ISSUE.
    always_comb begin
        cnt_d  = '0;
        expire = 1'b0;
        if (state_q == WAIT_BUSY || state_q == WAIT_DONE) begin
            cnt_d  = cnt_q + 1'b1;
            expire = (cnt_d == CNT_W'(TIMEOUT_CYCLES));
        end
        err_d = err_q | expire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    assign expire      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        scan_grant_d = scan_grant_q;
        host_grant_d = host_grant_q;
        scan_done_d  = 1'b0;
        host_done_d  = 1'b0;
        last_host_d  = last_host_q;
        finish       = 1'b0;
        // Tie goes to whoever was not served last.
        pick_host    = host_req && (!scan_req || !last_host_q);

        case (state_q)
            IDLE: begin
                // Skip the done cycle: the finishing requester still holds req.
                if (!pause && !scan_done_q && !host_done_q && (scan_req || host_req)) begin
                    addr_d       = pick_host ? host_addr : scan_addr;
                    scan_grant_d = !pick_host;
                    host_grant_d = pick_host;
                    state_d      = ISSUE;
                end
            end
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (mems_SPI_busy) state_d = WAIT_DONE;
            WAIT_DONE: if (!mems_SPI_busy) finish = 1'b1;
            default:   state_d = IDLE;
        endcase

        if (expire) finish = 1'b1;

        if (finish) begin
            state_d      = IDLE;
            scan_done_d  = scan_grant_q;
            host_done_d  = host_grant_q;
            scan_grant_d = 1'b0;
            host_grant_d = 1'b0;
            last_host_d  = host_grant_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            scan_grant_q <= 1'b0;
            host_grant_q <= 1'b0;
            scan_done_q  <= 1'b0;
            host_done_q  <= 1'b0;
            last_host_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            scan_grant_q <= scan_grant_d;
            host_grant_q <= host_grant_d;
            scan_done_q  <= scan_done_d;
            host_done_q  <= host_done_d;
            last_host_q  <= last_host_d;
        end
    end

    assign mems_SPI_start = (state_q == ISSUE);
    assign addr           = addr_q;
    assign scan_grant     = scan_grant_q;
    assign host_grant     = host_grant_q;
    assign scan_done      = scan_done_q;
    assign host_done      = host_done_q;

endmodule
